// File: rtl/relogio_pkg.sv
// Shared types, limits and the one-hot digit decoder for the time-set controller.
package relogio_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SET_HOUR,
      SET_MIN,
      COMMIT
   } state_t;

   localparam int HOUR_MAX       = 23;
   localparam int MIN_MAX        = 59;
   localparam int DIGIT_ONEHOT_W = 10;

   // Position of the single set bit; anything that is not exactly one-hot reads as 0.
   function automatic logic [3:0] onehot_to_bcd(input logic [DIGIT_ONEHOT_W-1:0] oh);
      logic [3:0]  idx;
      int unsigned hits;
      idx  = '0;
      hits = 0;
      for (int i = 0; i < DIGIT_ONEHOT_W; i++) begin
         if (oh[i]) begin
            idx  = 4'(i);
            hits = hits + 1;
         end
      end
      return (hits == 1) ? idx : 4'd0;
   endfunction

endpackage

// File: rtl/relogio_ajuste_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge press pulse.
module relogio_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
         // Counts consecutive samples that disagree with the accepted level.
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/relogio_ajuste.sv
// Time-set controller feeding the HH:MM:SS counter's parallel load.
// Optional build macro RELOGIO_AJUSTE_AUTOREPEAT_EN enables increment auto-repeat.
module relogio_ajuste
   import relogio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      btn_mode,
   input  logic                      btn_inc,
   input  logic [DIGIT_ONEHOT_W-1:0] cur_h1_oh,
   input  logic [DIGIT_ONEHOT_W-1:0] cur_h0_oh,
   input  logic [DIGIT_ONEHOT_W-1:0] cur_m1_oh,
   input  logic [DIGIT_ONEHOT_W-1:0] cur_m0_oh,
   output logic                      LD,
   output logic [1:0]                H_in1,
   output logic [3:0]                H_in0,
   output logic [3:0]                M_in1,
   output logic [3:0]                M_in0,
   output logic                      editing_hour,
   output logic                      editing_min
);

   localparam logic [1:0] H_TENS_MAX  = 2'(HOUR_MAX / 10);
   localparam logic [3:0] H_UNITS_MAX = 4'(HOUR_MAX % 10);
   localparam logic [3:0] M_TENS_MAX  = 4'(MIN_MAX / 10);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_h1;
   logic [3:0] r_h0;
   logic [3:0] r_m1;
   logic [3:0] r_m0;

   logic       w_mode_press;
   logic       w_inc_press;
   logic       w_inc_level;
   logic       w_unused_mode_level;
   logic       w_inc_evt;
   logic       w_load;
   logic       w_step_h;
   logic       w_step_m;

   logic [3:0] w_dec_h1;
   logic [3:0] w_dec_h0;
   logic [3:0] w_dec_m1;
   logic [3:0] w_dec_m0;
   logic [6:0] w_hour_val;
   logic [6:0] w_min_val;
   logic [1:0] w_load_h1;
   logic [3:0] w_load_h0;
   logic [3:0] w_load_m1;
   logic [3:0] w_load_m0;

   relogio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_mode),
      .level (w_unused_mode_level),
      .press (w_mode_press)
   );

   relogio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_inc),
      .level (w_inc_level),
      .press (w_inc_press)
   );

   assign w_dec_h1 = onehot_to_bcd(cur_h1_oh);
   assign w_dec_h0 = onehot_to_bcd(cur_h0_oh);
   assign w_dec_m1 = onehot_to_bcd(cur_m1_oh);
   assign w_dec_m0 = onehot_to_bcd(cur_m0_oh);

   // An impossible running time (e.g. a corrupted digit) starts the edit from 00.
   always_comb begin
      w_hour_val = 7'(w_dec_h1) * 7'd10 + 7'(w_dec_h0);
      w_min_val  = 7'(w_dec_m1) * 7'd10 + 7'(w_dec_m0);
      w_load_h1  = 2'(w_dec_h1);
      w_load_h0  = w_dec_h0;
      w_load_m1  = w_dec_m1;
      w_load_m0  = w_dec_m0;
      if (w_hour_val > 7'(HOUR_MAX)) begin
         w_load_h1 = '0;
         w_load_h0 = '0;
      end
      if (w_min_val > 7'(MIN_MAX)) begin
         w_load_m1 = '0;
         w_load_m0 = '0;
      end
   end

`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
   localparam int             REP_W    = $clog2(REPEAT_DELAY + 1);
   localparam logic [REP_W-1:0] REP_FIRE = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_WRAP = REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

   logic [REP_W-1:0] r_rep_cnt;
   logic             w_rep_fire;
   logic             w_editing;

   assign w_editing  = (r_state == SET_HOUR) || (r_state == SET_MIN);
   assign w_rep_fire = (r_rep_cnt == REP_FIRE);
   assign w_inc_evt  = w_inc_press | w_rep_fire;

   // Cycles since the press; zero means disarmed. Wraps back so fires recur every period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rep_cnt <= '0;
      end else if (!w_inc_level || !w_editing || (w_state_nxt != r_state)) begin
         r_rep_cnt <= '0;
      end else if (w_inc_press) begin
         r_rep_cnt <= REP_W'(1);
      end else if (w_rep_fire) begin
         r_rep_cnt <= REP_WRAP;
      end else if (r_rep_cnt != '0) begin
         r_rep_cnt <= r_rep_cnt + 1'b1;
      end
   end
`else
   logic w_unused_inc_level;
   assign w_unused_inc_level = w_inc_level;
   assign w_inc_evt          = w_inc_press;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Mode has priority over increment when both arrive together.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step_h    = 1'b0;
      w_step_m    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mode_press) begin
               w_state_nxt = SET_HOUR;
               w_load      = 1'b1;
            end
         end
         SET_HOUR: begin
            if (w_mode_press) begin
               w_state_nxt = SET_MIN;
            end else if (w_inc_evt) begin
               w_step_h = 1'b1;
            end
         end
         SET_MIN: begin
            if (w_mode_press) begin
               w_state_nxt = COMMIT;
            end else if (w_inc_evt) begin
               w_step_m = 1'b1;
            end
         end
         COMMIT: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h1 <= '0;
         r_h0 <= '0;
         r_m1 <= '0;
         r_m0 <= '0;
      end else if (w_load) begin
         r_h1 <= w_load_h1;
         r_h0 <= w_load_h0;
         r_m1 <= w_load_m1;
         r_m0 <= w_load_m0;
      end else if (w_step_h) begin
         if ((r_h1 == H_TENS_MAX) && (r_h0 == H_UNITS_MAX)) begin
            r_h1 <= '0;
            r_h0 <= '0;
         end else if (r_h0 == 4'd9) begin
            r_h1 <= r_h1 + 1'b1;
            r_h0 <= '0;
         end else begin
            r_h0 <= r_h0 + 1'b1;
         end
      end else if (w_step_m) begin
         if (r_m0 == 4'd9) begin
            r_m0 <= '0;
            r_m1 <= (r_m1 == M_TENS_MAX) ? 4'd0 : r_m1 + 1'b1;
         end else begin
            r_m0 <= r_m0 + 1'b1;
         end
      end
   end

   assign LD           = (r_state == COMMIT);
   assign editing_hour = (r_state == SET_HOUR);
   assign editing_min  = (r_state == SET_MIN);
   assign H_in1        = r_h1;
   assign H_in0        = r_h0;
   assign M_in1        = r_m1;
   assign M_in0        = r_m0;

endmodule

// File: tb/tb_relogio_ajuste.sv
// Self-checking bench for relogio_ajuste: cycle-level behavioural model plus directed literal checks.
module tb_relogio_ajuste;

   localparam int D  = 4;
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
   localparam int RD = 20;
   localparam int RP = 5;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [9:0] cur_h1_oh = 10'd0;
   logic [9:0] cur_h0_oh = 10'd0;
   logic [9:0] cur_m1_oh = 10'd0;
   logic [9:0] cur_m0_oh = 10'd0;
   logic       LD;
   logic [1:0] H_in1;
   logic [3:0] H_in0;
   logic [3:0] M_in1;
   logic [3:0] M_in0;
   logic       editing_hour;
   logic       editing_min;

   int checks = 0;
   int failures = 0;
   int ld_cnt = 0;
   int cap_h1 = -1, cap_h0 = -1, cap_m1 = -1, cap_m0 = -1;

   relogio_ajuste #(
      .DEBOUNCE_CYCLES(D)
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
`endif
   ) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_h1_oh(cur_h1_oh), .cur_h0_oh(cur_h0_oh), .cur_m1_oh(cur_m1_oh), .cur_m0_oh(cur_m0_oh),
      .LD(LD), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .editing_hour(editing_hour), .editing_min(editing_min)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_hm = '0, m_hi = '0;          // raw samples, bit 0 = newest
   bit m_lm = 0, m_li = 0, m_lpm = 0, m_lpi = 0; // debounced levels and their previous values
   bit m_pm = 0, m_pi = 0, m_rep = 0;           // pulses visible after the last edge
   int m_st = 0, m_eh = 0, m_em = 0, m_n = 0;   // 0 idle, 1 hour, 2 min, 3 commit
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
   bit m_armed = 0;
   int m_t0 = 0;
`endif

   function automatic int dec_digit(input logic [9:0] v);
      if ($countones(v) != 1) return 0;
      for (int i = 0; i < 10; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic int dec_val(input logic [9:0] t, input logic [9:0] u, input int maxv);
      int v;
      v = dec_digit(t) * 10 + dec_digit(u);
      return (v > maxv) ? 0 : v;
   endfunction

   // True when the last D samples reaching the stability counter all disagree with lvl.
   function automatic bit flips(input logic [15:0] h, input bit lvl);
      for (int k = 2; k <= D + 1; k++) if (h[k] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [9:0] oh(input int d);
      logic [9:0] one;
      one = 10'd1;
      return one << d;
   endfunction

   task automatic model_step();
      bit pm, pi;
      int st_old;
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
      bit li_before;
      li_before = m_li;
`endif
      if (reset) begin
         m_hm = '0; m_hi = '0; m_lm = 0; m_li = 0; m_lpm = 0; m_lpi = 0;
         m_pm = 0; m_pi = 0; m_rep = 0; m_st = 0; m_eh = 0; m_em = 0; m_n = 0;
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
         m_armed = 0; m_t0 = 0;
`endif
         return;
      end
      pm = m_pm;
      pi = m_pi | m_rep;
      st_old = m_st;
      case (m_st)
         0: if (pm) begin
               m_eh = dec_val(cur_h1_oh, cur_h0_oh, 23);
               m_em = dec_val(cur_m1_oh, cur_m0_oh, 59);
               m_st = 1;
            end
         1: if (pm) m_st = 2; else if (pi) m_eh = (m_eh + 1) % 24;
         2: if (pm) m_st = 3; else if (pi) m_em = (m_em + 1) % 60;
         default: m_st = 0;
      endcase
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
      if (m_pi && (st_old == 1 || st_old == 2) && m_st == st_old) begin
         m_armed = 1;
         m_t0 = m_n;
      end
      if (!li_before || m_st != st_old || !(st_old == 1 || st_old == 2)) m_armed = 0;
`endif
      m_n++;
      m_hm = {m_hm[14:0], btn_mode};
      m_hi = {m_hi[14:0], btn_inc};
      m_pm = m_lm & ~m_lpm;
      m_pi = m_li & ~m_lpi;
      m_lpm = m_lm;
      m_lpi = m_li;
      if (flips(m_hm, m_lm)) m_lm = ~m_lm;
      if (flips(m_hi, m_li)) m_li = ~m_li;
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
      m_rep = m_armed && (m_n - m_t0 >= RD) && (((m_n - m_t0 - RD) % RP) == 0);
`else
      m_rep = 0;
`endif
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      logic [16:0] act, exp;
      @(posedge clk);
      #1;
      act = {LD, H_in1, H_in0, M_in1, M_in0, editing_hour, editing_min};
      exp = {m_st == 3, 2'(m_eh / 10), 4'(m_eh % 10), 4'(m_em / 10), 4'(m_em % 10),
             m_st == 1, m_st == 2};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL cycle t=%0t outputs got %h expected %h", $time, act, exp);
      end
      if (LD === 1'b1) begin
         ld_cnt++;
         cap_h1 = int'(H_in1); cap_h0 = int'(H_in0); cap_m1 = int'(M_in1); cap_m0 = int'(M_in0);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_time(input string name, input int h1, input int h0, input int m1, input int m0);
      chk({name, ".H_in1"}, int'(H_in1), h1);
      chk({name, ".H_in0"}, int'(H_in0), h0);
      chk({name, ".M_in1"}, int'(M_in1), m1);
      chk({name, ".M_in0"}, int'(M_in0), m0);
   endtask

   task automatic set_time(input int hh, input int mm);
      cur_h1_oh = oh(hh / 10);
      cur_h0_oh = oh(hh % 10);
      cur_m1_oh = oh(mm / 10);
      cur_m0_oh = oh(mm % 10);
   endtask

   task automatic press(input bit mode, input bit inc, input int hold);
      @(negedge clk);
      if (mode) btn_mode = 1'b1;
      if (inc)  btn_inc  = 1'b1;
      repeat (hold) @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic do_reset(input int hh, input int mm);
      @(negedge clk);
      reset = 1'b1;
      set_time(hh, mm);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int ld0;
      // 1: reset state and capture of 12:34
      set_time(12, 34);
      repeat (3) @(negedge clk);
      chk("reset.LD", int'(LD), 0);
      chk("reset.editing_hour", int'(editing_hour), 0);
      chk("reset.editing_min", int'(editing_min), 0);
      chk_time("reset", 0, 0, 0, 0);
      reset = 1'b0;
      press(1, 0, 8);
      chk("capture.editing_hour", int'(editing_hour), 1);
      chk_time("capture", 1, 2, 3, 4);

      // 2: hour and minute wrap
      do_reset(22, 58);
      press(1, 0, 8);
      chk_time("load22", 2, 2, 5, 8);
      press(0, 1, 8);
      chk_time("hour23", 2, 3, 5, 8);
      press(0, 1, 8);
      chk_time("hour00", 0, 0, 5, 8);
      press(1, 0, 8);
      chk("setmin.editing_min", int'(editing_min), 1);
      press(0, 1, 8);
      chk_time("min59", 0, 0, 5, 9);
      press(0, 1, 8);
      chk_time("min00", 0, 0, 0, 0);

      // 3: bouncy increment, then stable high
      for (int i = 0; i < 5; i++) begin
         btn_inc = 1'b1;
         repeat (3) @(negedge clk);
         btn_inc = 1'b0;
         repeat (3) @(negedge clk);
      end
      btn_inc = 1'b1;
      repeat (7) @(posedge clk);
      #1 chk("bounce.before_step", int'(M_in0), 0);
      @(posedge clk);
      #1 chk("bounce.step_edge8", int'(M_in0), 1);
      repeat (3) @(negedge clk);
      btn_inc = 1'b0;
      repeat (12) @(negedge clk);
      chk_time("bounce.once", 0, 0, 0, 1);

      // 4: full edit to 09:59 and commit
      do_reset(8, 58);
      press(1, 0, 8);
      press(0, 1, 8);
      press(1, 0, 8);
      press(0, 1, 8);
      ld0 = ld_cnt;
      press(1, 0, 8);
      chk("commit.ld_pulses", ld_cnt - ld0, 1);
      chk("commit.cap_h1", cap_h1, 0);
      chk("commit.cap_h0", cap_h0, 9);
      chk("commit.cap_m1", cap_m1, 5);
      chk("commit.cap_m0", cap_m0, 9);
      chk("commit.idle_hour", int'(editing_hour), 0);
      chk("commit.idle_min", int'(editing_min), 0);
      chk_time("commit.hold", 0, 9, 5, 9);

      // 5: coincident presses, reset mid-edit, decoder corner cases
      set_time(7, 15);
      press(1, 0, 8);
      chk_time("load07", 0, 7, 1, 5);
      press(1, 1, 8);
      chk("coinc.editing_min", int'(editing_min), 1);
      chk_time("coinc", 0, 7, 1, 5);
      ld0 = ld_cnt;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset.editing_min", int'(editing_min), 0);
      chk("midreset.LD", int'(LD), 0);
      chk_time("midreset", 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("midreset.no_ld", ld_cnt - ld0, 0);
      cur_h1_oh = oh(1);
      cur_h0_oh = 10'b0000000011;
      cur_m1_oh = oh(2);
      cur_m0_oh = oh(0);
      press(1, 0, 8);
      chk_time("twohot", 1, 0, 2, 0);
      press(1, 0, 8);
      press(1, 0, 8);
      cur_h1_oh = oh(2);
      cur_h0_oh = oh(5);
      cur_m1_oh = oh(7);
      cur_m0_oh = oh(0);
      press(1, 0, 8);
      chk_time("range", 0, 0, 0, 0);

      // 6: long increment hold in SET_MIN from 00
      press(1, 0, 8);
      press(0, 1, 50);
`ifdef RELOGIO_AJUSTE_AUTOREPEAT_EN
      chk_time("hold50", 0, 0, 0, 7);
`else
      chk_time("hold50", 0, 0, 0, 1);
`endif
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
